// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// ctrl_decode_stage: RV32 control decode with a one-cycle registered bundle.
// Optional M-extension (multi-cycle divide blocking) under CTRL_DECODE_MEXT_EN.
// Revision: 1.0
// ============================================================================
module ctrl_decode_stage #(
  parameter int ALU_CTRL_W = 4,
  parameter int DIV_LAT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d,
  input  logic                  valid_d,
  output logic                  ready_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic [1:0]            result_src_e,
  output logic                  mem_write_e,
  output logic                  mem_read_e,
  output logic                  jump_e,
  output logic                  branch_e,
  output logic                  alu_src_e,
  output logic                  alu_src_a_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [2:0]            branch_type_e,
  output logic                  illegal_e,
  output logic                  busy
`ifdef CTRL_DECODE_MEXT_EN
  ,
  output logic                  md_en_e,
  output logic [2:0]            md_op_e
`endif
);

  localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_BLOCK = 1'b1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3,  ALU_XOR  = 4'd4,  ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6, ALU_SLL  = 4'd7,  ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9,  ALU_PASSB = 4'd10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;
  assign opcode       = instr_d[6:0];
  assign funct3       = instr_d[14:12];
  assign funct7       = instr_d[31:25];
  assign unused_instr = ^{instr_d[24:15], instr_d[11:7]};

  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  f3_alu = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  logic       dec_rw, dec_mw, dec_mr, dec_j, dec_b, dec_as, dec_asa, dec_ill;
  logic [1:0] dec_rs;
  logic [2:0] dec_bt;
  logic [3:0] dec_alu;
  logic       dec_md_en;
  logic [2:0] dec_md_op;
  logic       dec_block;

  always_comb begin
    dec_rw = 1'b0; dec_mw = 1'b0; dec_mr = 1'b0; dec_j = 1'b0; dec_b = 1'b0;
    dec_as = 1'b0; dec_asa = 1'b0; dec_ill = 1'b0; dec_rs = 2'b00; dec_bt = 3'b000;
    dec_alu = ALU_ADD; dec_md_en = 1'b0; dec_md_op = 3'b000;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec_rw  = 1'b1;
          dec_alu = f3_alu(funct3, funct7[5], 1'b1);
`ifdef CTRL_DECODE_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          dec_rw    = 1'b1;
          dec_md_en = 1'b1;
          dec_md_op = funct3;
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_I:      begin dec_rw = 1'b1; dec_as = 1'b1; dec_alu = f3_alu(funct3, funct7[5], 1'b0); end
      OP_LOAD:   begin dec_rw = 1'b1; dec_rs = 2'b01; dec_as = 1'b1; dec_mr = 1'b1; end
      OP_STORE:  begin dec_mw = 1'b1; dec_as = 1'b1; end
      OP_BRANCH: begin dec_b = 1'b1; dec_alu = ALU_SUB; dec_bt = funct3; end
      OP_JALR:   begin dec_rw = 1'b1; dec_j = 1'b1; dec_rs = 2'b10; dec_as = 1'b1; end
      OP_JAL:    begin dec_rw = 1'b1; dec_j = 1'b1; dec_rs = 2'b10; end
      OP_LUI:    begin dec_rw = 1'b1; dec_as = 1'b1; dec_alu = ALU_PASSB; end
      OP_AUIPC:  begin dec_rw = 1'b1; dec_as = 1'b1; dec_asa = 1'b1; end
      default:   dec_ill = 1'b1;
    endcase
  end

  // Only DIV/DIVU/REM/REMU hold off issue; without the M-extension nothing blocks.
  assign dec_block = dec_md_en & funct3[2];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = valid_d & ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_e) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      if (accept && dec_block) begin
        state_d = S_BLOCK;
        cnt_d   = CNT_LOAD;
      end
    end else if (cnt_q <= CNT_W'(1)) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    ready_d = !stall_e && !flush_e && (state_q == S_RUN);
    busy    = (state_q == S_BLOCK);
  end

  logic       md_en_q;
  logic [2:0] md_op_q;

  always_ff @(posedge clk) begin
    if (rst || flush_e || (!stall_e && !accept)) begin
      valid_e <= 1'b0; reg_write_e <= 1'b0; result_src_e <= 2'b00; mem_write_e <= 1'b0;
      mem_read_e <= 1'b0; jump_e <= 1'b0; branch_e <= 1'b0; alu_src_e <= 1'b0;
      alu_src_a_e <= 1'b0; alu_ctrl_e <= '0; branch_type_e <= 3'b000; illegal_e <= 1'b0;
      md_en_q <= 1'b0; md_op_q <= 3'b000;
    end else if (accept) begin
      valid_e <= 1'b1; reg_write_e <= dec_rw; result_src_e <= dec_rs; mem_write_e <= dec_mw;
      mem_read_e <= dec_mr; jump_e <= dec_j; branch_e <= dec_b; alu_src_e <= dec_as;
      alu_src_a_e <= dec_asa; alu_ctrl_e <= ALU_CTRL_W'(dec_alu); branch_type_e <= dec_bt;
      illegal_e <= dec_ill; md_en_q <= dec_md_en; md_op_q <= dec_md_op;
    end
  end

`ifdef CTRL_DECODE_MEXT_EN
  assign md_en_e = md_en_q;
  assign md_op_e = md_op_q;
`else
  logic unused_md;
  assign unused_md = ^{md_en_q, md_op_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_ctrl_decode_stage: directed self-checking bench for ctrl_decode_stage.
// Revision: 1.0
// ============================================================================
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d, stall_e, flush_e;
  logic        ready_d, valid_e, busy;
  logic        reg_write_e, mem_write_e, mem_read_e, jump_e, branch_e;
  logic        alu_src_e, alu_src_a_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_ctrl_e;
  logic [2:0]  branch_type_e;
`ifdef CTRL_DECODE_MEXT_EN
  logic        md_en_e;
  logic [2:0]  md_op_e;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.ALU_CTRL_W(4), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .ready_d(ready_d),
    .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .alu_src_a_e(alu_src_a_e), .alu_ctrl_e(alu_ctrl_e), .branch_type_e(branch_type_e),
    .illegal_e(illegal_e), .busy(busy)
`ifdef CTRL_DECODE_MEXT_EN
    , .md_en_e(md_en_e), .md_op_e(md_op_e)
`endif
  );

  // {reg_write, result_src, mem_write, mem_read, jump, branch, alu_src, alu_src_a, alu_ctrl, branch_type, illegal}
  logic [16:0] bund;
  assign bund = {reg_write_e, result_src_e, mem_write_e, mem_read_e, jump_e, branch_e,
                 alu_src_e, alu_src_a_e, alu_ctrl_e, branch_type_e, illegal_e};

  function automatic logic [16:0] bx(input logic rw, input logic [1:0] rs, input logic mw,
                                     input logic mr, input logic j, input logic b,
                                     input logic as, input logic asa, input logic [3:0] alu,
                                     input logic [2:0] bt, input logic ill);
    bx = {rw, rs, mw, mr, j, b, as, asa, alu, bt, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_SUB   = 32'h403100B3;
  localparam logic [31:0] I_XOR   = 32'h003140B3;
  localparam logic [31:0] I_LW    = 32'h00812283;
  localparam logic [31:0] I_SW    = 32'h00512623;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BGEU  = 32'h0020F463;
  localparam logic [31:0] I_JAL   = 32'h010000EF;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_LUI   = 32'h123451B7;
  localparam logic [31:0] I_AUIPC = 32'h00001217;
  localparam logic [31:0] I_SRAI  = 32'h40515093;
  localparam logic [31:0] I_ADDI7 = 32'h40010093;
  localparam logic [31:0] I_BADOP = 32'h0000007F;
  localparam logic [31:0] I_BADF7 = 32'h423100B3;
  localparam logic [31:0] I_MUL   = 32'h023100B3;
  localparam logic [31:0] I_DIV   = 32'h023140B3;

  localparam logic [16:0] B_ZERO  = 17'd0;
  localparam logic [16:0] B_ILL   = 17'd1;

  initial begin
    rst = 1'b1; instr_d = I_ADD; valid_d = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(valid_e), 32'd0);
    chk("rst_bundle", 32'(bund), 32'(B_ZERO));
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_run", 32'(ready_d), 32'd1);

    // Back-to-back stream, one instruction per cycle
    instr_d = I_ADD;   cyc(); chk("add", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,0,0,4'd0,3'd0,0)));
    chk("add_valid", 32'(valid_e), 32'd1);
    instr_d = I_LW;    cyc(); chk("lw", 32'(bund), 32'(bx(1,2'b01,0,1,0,0,1,0,4'd0,3'd0,0)));
    instr_d = I_SW;    cyc(); chk("sw", 32'(bund), 32'(bx(0,2'b00,1,0,0,0,1,0,4'd0,3'd0,0)));
    instr_d = I_BEQ;   cyc(); chk("beq", 32'(bund), 32'(bx(0,2'b00,0,0,0,1,0,0,4'd1,3'd0,0)));
    instr_d = I_JAL;   cyc(); chk("jal", 32'(bund), 32'(bx(1,2'b10,0,0,1,0,0,0,4'd0,3'd0,0)));
    instr_d = I_LUI;   cyc(); chk("lui", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,1,0,4'd10,3'd0,0)));
    instr_d = I_AUIPC; cyc(); chk("auipc", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,1,1,4'd0,3'd0,0)));
    chk("auipc_valid", 32'(valid_e), 32'd1);
    instr_d = I_SUB;   cyc(); chk("sub", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,0,0,4'd1,3'd0,0)));
    instr_d = I_XOR;   cyc(); chk("xor", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,0,0,4'd4,3'd0,0)));
    instr_d = I_BGEU;  cyc(); chk("bgeu", 32'(bund), 32'(bx(0,2'b00,0,0,0,1,0,0,4'd1,3'd7,0)));
    instr_d = I_JALR;  cyc(); chk("jalr", 32'(bund), 32'(bx(1,2'b10,0,0,1,0,1,0,4'd0,3'd0,0)));
    instr_d = I_SRAI;  cyc(); chk("srai", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,1,0,4'd9,3'd0,0)));
    instr_d = I_ADDI7; cyc(); chk("addi_f7", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,1,0,4'd0,3'd0,0)));

    // Illegal encodings
    instr_d = I_BADOP; cyc(); chk("bad_op", 32'(bund), 32'(B_ILL));
    chk("bad_op_valid", 32'(valid_e), 32'd1);
    instr_d = I_BADF7; cyc(); chk("bad_f7", 32'(bund), 32'(B_ILL));
`ifndef CTRL_DECODE_MEXT_EN
    instr_d = I_MUL;   cyc(); chk("mul_illegal", 32'(bund), 32'(B_ILL));
    chk("mul_no_busy", 32'(busy), 32'd0);
`endif

    // Bubble
    valid_d = 1'b0; cyc();
    chk("bubble_valid", 32'(valid_e), 32'd0);
    chk("bubble_bundle", 32'(bund), 32'(B_ZERO));

    // LW then three stalled cycles with ADD waiting
    valid_d = 1'b1; instr_d = I_LW; cyc();
    stall_e = 1'b1; instr_d = I_ADD; #1;
    chk("stall_ready", 32'(ready_d), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", 32'(bund), 32'(bx(1,2'b01,0,1,0,0,1,0,4'd0,3'd0,0)));
      chk("stall_valid", 32'(valid_e), 32'd1);
    end
    stall_e = 1'b0; #1;
    chk("unstall_ready", 32'(ready_d), 32'd1);
    cyc();
    chk("after_stall", 32'(bund), 32'(bx(1,2'b00,0,0,0,0,0,0,4'd0,3'd0,0)));

    // Flush beats stall and accept
    instr_d = I_LW; stall_e = 1'b1; flush_e = 1'b1; #1;
    chk("flush_ready", 32'(ready_d), 32'd0);
    cyc();
    chk("flush_valid", 32'(valid_e), 32'd0);
    chk("flush_bundle", 32'(bund), 32'(B_ZERO));
    stall_e = 1'b0; flush_e = 1'b0;
    cyc();
    chk("post_flush_lw", 32'(bund), 32'(bx(1,2'b01,0,1,0,0,1,0,4'd0,3'd0,0)));

    // Reset overrides accept
    rst = 1'b1; instr_d = I_JAL; cyc();
    chk("rst_ovr_valid", 32'(valid_e), 32'd0);
    chk("rst_ovr_bundle", 32'(bund), 32'(B_ZERO));
    rst = 1'b0;

`ifdef CTRL_DECODE_MEXT_EN
    // DIV blocks issue for DIV_LAT-1 cycles; MUL waits
    instr_d = I_DIV; cyc();
    chk("div_md_en", 32'(md_en_e), 32'd1);
    chk("div_md_op", 32'(md_op_e), 32'd4);
    chk("div_rw", 32'(reg_write_e), 32'd1);
    instr_d = I_MUL;
    for (int i = 0; i < 7; i++) begin
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_ready", 32'(ready_d), 32'd0);
      cyc();
    end
    chk("div_done_busy", 32'(busy), 32'd0);
    chk("div_done_ready", 32'(ready_d), 32'd1);
    cyc();
    chk("mul_valid", 32'(valid_e), 32'd1);
    chk("mul_md_en", 32'(md_en_e), 32'd1);
    chk("mul_md_op", 32'(md_op_e), 32'd0);
    chk("mul_no_block", 32'(busy), 32'd0);

    // Flush on the third busy cycle
    instr_d = I_DIV; cyc();
    valid_d = 1'b0; cyc(); cyc();
    chk("blk3_busy", 32'(busy), 32'd1);
    flush_e = 1'b1; cyc();
    flush_e = 1'b0; #1;
    chk("flush_blk_busy", 32'(busy), 32'd0);
    chk("flush_blk_ready", 32'(ready_d), 32'd1);

    // Reset mid-block
    valid_d = 1'b1; instr_d = I_DIV; cyc();
    valid_d = 1'b0; cyc();
    rst = 1'b1; cyc();
    chk("rst_blk_busy", 32'(busy), 32'd0);
    rst = 1'b0; #1;
    chk("rst_blk_ready", 32'(ready_d), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
